secuenciador_control: RTL and testbench

Fetch/decode/execute control unit for the 8-bit UAZ micro. It is the write-side master of the 8x8 register file. It fetches 16-bit instructions from program memory over a req/ack handshake and decodes them. It drives the register file's HAB/RX/RY/DATO/RESUL/PC_VAL inputs and consumes its RX_DATO/RY_DATO/R0_DATO outputs. It contains the PC and an internal combinational ALU.

---
 rtl/micro_uaz_pkg.sv | 10 +
 rtl/alu_uaz.sv | 15 +
 rtl/secuenciador_control.sv | 106 ++++++++++
 tb/tb_secuenciador_control.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_uaz_pkg.sv
// micro_uaz_pkg: opcodes, register-file write codes, field positions and FSM states of the UAZ micro
package micro_uaz_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_OR = 4'h5, OP_MOV = 4'h6, OP_JMP = 4'h7,
                         OP_JZ = 4'h8, OP_CALL = 4'h9, OP_RET = 4'hA, OP_HLT = 4'hF;
  localparam logic [2:0] HAB_NADA = 3'b000, HAB_R0 = 3'b001, HAB_R7 = 3'b011, HAB_RX = 3'b100;
  localparam int OP_MSB = 15, OP_LSB = 12, RX_MSB = 11, RX_LSB = 9;
  localparam int RY_MSB = 2, RY_LSB = 0, IMM_MSB = 7, IMM_LSB = 0;
  typedef enum logic [1:0] {BUSCAR, DECODIF, EJECUTAR, ALTO} estado_t;
endpackage

// File: rtl/alu_uaz.sv
// alu_uaz: combinational 8-bit ALU for ADD/SUB/AND/OR, wrapping, no carry
module alu_uaz
  import micro_uaz_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] resul
);
  always_comb
    resul = op == OP_ADD ? a + b :
            op == OP_SUB ? a - b :
            op == OP_AND ? a & b :
            op == OP_OR  ? a | b : 8'h00;
endmodule

// File: rtl/secuenciador_control.sv
// secuenciador_control: fetch/decode/execute control unit of the UAZ micro (PC, IR, fetch timeout, FSM).
// Optional single-step mode via SECUENCIADOR_PASO_EN adds the PASO input.
module secuenciador_control
  import micro_uaz_pkg::*;
#(
  parameter logic [7:0] PC_INICIO  = 8'h00,
  parameter logic [3:0] MAX_ESPERA = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SECUENCIADOR_PASO_EN
  input  logic        PASO,
`endif
  input  logic [15:0] PM_DATO,
  input  logic        PM_ACK,
  input  logic [7:0]  RX_DATO,
  input  logic [7:0]  RY_DATO,
  input  logic [7:0]  R0_DATO,
  output logic [7:0]  PM_ADDR,
  output logic        PM_REQ,
  output logic [2:0]  HAB,
  output logic [2:0]  RX,
  output logic [2:0]  RY,
  output logic [7:0]  DATO,
  output logic [7:0]  RESUL,
  output logic [7:0]  PC_VAL,
  output logic        DETENIDO,
  output logic        ERROR
);
  estado_t     estado;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic [3:0]  espera;
  logic [3:0]  op;
  logic [7:0]  imm;
  logic [7:0]  pc_sig;
  logic        habil;
  logic        vence;
  logic        ilegal;
  logic        ir_unused;
`ifdef SECUENCIADOR_PASO_EN
  logic paso_d;
  logic paso_pend;
  // a captured PASO rising edge licenses exactly one fetch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      paso_d    <= 1'b0;
      paso_pend <= 1'b0;
    end else begin
      paso_d    <= PASO;
      paso_pend <= (PASO & ~paso_d) | (paso_pend & ~(estado == BUSCAR && PM_ACK && !vence));
    end
  assign habil = paso_pend;
`else
  assign habil = 1'b1;
`endif
  assign op        = ir[OP_MSB:OP_LSB];
  assign imm       = ir[IMM_MSB:IMM_LSB];
  assign ir_unused = ir[8];
  assign RX        = op == OP_RET ? 3'd7 : ir[RX_MSB:RX_LSB];
  assign RY        = ir[RY_MSB:RY_LSB];
  assign PC_VAL    = pc + 8'd1;
  assign PM_ADDR   = pc;
  assign PM_REQ    = estado == BUSCAR && habil && !reset;
  assign DETENIDO  = estado == ALTO;
  assign DATO      = op == OP_LDI ? imm : RY_DATO;
  assign ilegal    = op inside {[4'hB:4'hE]};
  assign vence     = estado == BUSCAR && habil && espera == MAX_ESPERA - 4'd1;
  alu_uaz u_alu (.op(op), .a(RX_DATO), .b(RY_DATO), .resul(RESUL));
  always_comb
    HAB = estado != EJECUTAR ? HAB_NADA :
          op == OP_LDI || op == OP_MOV ? HAB_RX :
          op inside {OP_ADD, OP_SUB, OP_AND, OP_OR} ? HAB_R0 :
          op == OP_CALL ? HAB_R7 : HAB_NADA;
  always_comb
    pc_sig = op == OP_JMP || op == OP_CALL || (op == OP_JZ && R0_DATO == 8'h00) ? imm :
             op == OP_RET ? RX_DATO : PC_VAL;
  // the last permitted wait cycle times out even if PM_ACK shows up in it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado <= BUSCAR;
      pc     <= PC_INICIO;
      ir     <= '0;
      espera <= '0;
      ERROR  <= 1'b0;
    end else
      case (estado)
        BUSCAR:
          if (vence) begin
            ERROR  <= 1'b1;
            estado <= ALTO;
          end else if (habil && PM_ACK) begin
            ir     <= PM_DATO;
            espera <= '0;
            estado <= DECODIF;
          end else if (habil)
            espera <= espera + 4'd1;
        DECODIF: estado <= EJECUTAR;
        EJECUTAR: begin
          pc     <= pc_sig;
          ERROR  <= ERROR | ilegal;
          estado <= op == OP_HLT ? ALTO : BUSCAR;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_secuenciador_control.sv
// tb_secuenciador_control: directed and randomized checks of secuenciador_control against an instruction-level model
module tb_secuenciador_control;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PM_ACK = 1'b0;
  logic [15:0] PM_DATO;
  logic [7:0]  RX_DATO, RY_DATO, R0_DATO, PM_ADDR, DATO, RESUL, PC_VAL;
  logic [2:0]  HAB, RX, RY;
  logic        PM_REQ, DETENIDO, ERROR;
  logic [15:0] mem [256];
  logic [7:0]  rf [8];
  logic [7:0]  init_rf [8];
  logic [7:0]  m [8];
  logic [7:0]  m_pc;
  logic        m_err;
  logic [2:0]  last_hab, last_rx;
  logic [7:0]  last_resul, last_pcval;
  int checks = 0;
  int failures = 0;

  secuenciador_control dut (
    .clk(clk), .reset(reset), .PM_DATO(PM_DATO), .PM_ACK(PM_ACK),
    .RX_DATO(RX_DATO), .RY_DATO(RY_DATO), .R0_DATO(R0_DATO),
    .PM_ADDR(PM_ADDR), .PM_REQ(PM_REQ), .HAB(HAB), .RX(RX), .RY(RY),
    .DATO(DATO), .RESUL(RESUL), .PC_VAL(PC_VAL), .DETENIDO(DETENIDO), .ERROR(ERROR)
  );

  always #5 clk = ~clk;
  assign PM_DATO = mem[PM_ADDR];
  assign RX_DATO = rf[RX];
  assign RY_DATO = rf[RY];
  assign R0_DATO = rf[0];

  // register file the sequencer writes into
  always @(posedge clk)
    if (reset) rf <= init_rf;
    else if (HAB == 3'b100) rf[RX] <= DATO;
    else if (HAB == 3'b001) rf[0] <= RESUL;
    else if (HAB == 3'b011) rf[7] <= PC_VAL;

  task automatic clear_env;
    mem = '{default: 16'h0000};
    init_rf = '{default: 8'h00};
  endtask

  task automatic do_reset;
    reset = 1'b1;
    PM_ACK = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (PM_REQ !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", PM_REQ); end
    if (HAB !== 3'b000) begin failures++; $display("FAIL rst_hab got=%b exp=000", HAB); end
    if (DETENIDO !== 1'b0) begin failures++; $display("FAIL rst_det got=%b exp=0", DETENIDO); end
    if (PM_ADDR !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", PM_ADDR); end
    if (ERROR !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", ERROR); end
    reset = 1'b0;
    m = init_rf;
    m_pc = 8'h00;
    m_err = 1'b0;
    #1;
  endtask

  // one instruction: fetch with d cycles of ACK delay, decode, execute, compared to the ISA model
  task automatic step(input int d);
    logic [15:0] i;
    logic [3:0]  o;
    logic [2:0]  x, y, e_hab;
    logic [7:0]  im, npc, e_val;
    bit          halt;
    checks += 3;
    if (PM_REQ !== 1'b1) begin failures++; $display("FAIL fetch_req got=%b exp=1", PM_REQ); end
    if (PM_ADDR !== m_pc) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", PM_ADDR, m_pc); end
    if (ERROR !== m_err) begin failures++; $display("FAIL error_flag pc=%h got=%b exp=%b", m_pc, ERROR, m_err); end
    PM_ACK = 1'b0;
    repeat (d) @(negedge clk);
    PM_ACK = 1'b1;
    @(negedge clk);
    PM_ACK = 1'b0;
    i = mem[m_pc];
    o = i[15:12];
    x = i[11:9];
    y = i[2:0];
    im = i[7:0];
    checks++;
    if (HAB !== 3'b000) begin failures++; $display("FAIL decode_hab got=%b exp=000", HAB); end
    @(negedge clk);
    npc = m_pc + 8'd1;
    e_hab = 3'b000;
    e_val = 8'h00;
    halt = 1'b0;
    case (o)
      4'h0: ;
      4'h1: begin e_hab = 3'b100; e_val = im; m[x] = im; end
      4'h2: begin e_hab = 3'b001; e_val = m[x] + m[y]; m[0] = e_val; end
      4'h3: begin e_hab = 3'b001; e_val = m[x] - m[y]; m[0] = e_val; end
      4'h4: begin e_hab = 3'b001; e_val = m[x] & m[y]; m[0] = e_val; end
      4'h5: begin e_hab = 3'b001; e_val = m[x] | m[y]; m[0] = e_val; end
      4'h6: begin e_hab = 3'b100; e_val = m[y]; m[x] = e_val; end
      4'h7: npc = im;
      4'h8: npc = m[0] == 8'h00 ? im : m_pc + 8'd1;
      4'h9: begin e_hab = 3'b011; e_val = m_pc + 8'd1; m[7] = e_val; npc = im; end
      4'hA: npc = m[7];
      4'hF: halt = 1'b1;
      default: m_err = 1'b1;
    endcase
    last_hab = HAB;
    last_rx = RX;
    last_resul = RESUL;
    last_pcval = PC_VAL;
    checks++;
    if (HAB !== e_hab) begin failures++; $display("FAIL exec_hab pc=%h ir=%h got=%b exp=%b", m_pc, i, HAB, e_hab); end
    if (e_hab == 3'b100) begin
      checks += 2;
      if (DATO !== e_val) begin failures++; $display("FAIL exec_dato ir=%h got=%h exp=%h", i, DATO, e_val); end
      if (RX !== x) begin failures++; $display("FAIL exec_rx ir=%h got=%h exp=%h", i, RX, x); end
    end
    if (e_hab == 3'b001) begin
      checks++;
      if (RESUL !== e_val) begin failures++; $display("FAIL exec_resul ir=%h got=%h exp=%h", i, RESUL, e_val); end
    end
    if (e_hab == 3'b011) begin
      checks++;
      if (PC_VAL !== e_val) begin failures++; $display("FAIL exec_pcval ir=%h got=%h exp=%h", i, PC_VAL, e_val); end
    end
    if (o == 4'hA) begin
      checks++;
      if (RX !== 3'd7) begin failures++; $display("FAIL ret_rx got=%h exp=7", RX); end
    end
    @(negedge clk);
    m_pc = npc;
    if (halt) begin
      checks += 2;
      if (DETENIDO !== 1'b1) begin failures++; $display("FAIL hlt_det got=%b exp=1", DETENIDO); end
      if (PM_REQ !== 1'b0) begin failures++; $display("FAIL hlt_req got=%b exp=0", PM_REQ); end
    end
  endtask

  task automatic test_reset;
    clear_env();
    do_reset();
    checks += 2;
    if (PM_REQ !== 1'b1) begin failures++; $display("FAIL post_rst_req got=%b exp=1", PM_REQ); end
    if (DETENIDO !== 1'b0) begin failures++; $display("FAIL post_rst_det got=%b exp=0", DETENIDO); end
  endtask

  task automatic test_program;
    logic [2:0] eh;
    clear_env();
    mem[0] = 16'h1205;
    mem[1] = 16'h1403;
    mem[2] = 16'h2202;
    mem[3] = 16'hF000;
    do_reset();
    PM_ACK = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      eh = (c == 3 || c == 6) ? 3'b100 : c == 9 ? 3'b001 : 3'b000;
      checks++;
      if (HAB !== eh) begin failures++; $display("FAIL prog_hab cyc=%0d got=%b exp=%b", c, HAB, eh); end
      if (c == 3 || c == 6) begin
        checks++;
        if (DATO !== (c == 3 ? 8'h05 : 8'h03)) begin failures++; $display("FAIL prog_dato cyc=%0d got=%h", c, DATO); end
      end
      if (c == 9) begin
        checks++;
        if (RESUL !== 8'h08) begin failures++; $display("FAIL prog_resul got=%h exp=08", RESUL); end
      end
      if (c % 3 == 1 && c < 13) begin
        checks++;
        if (PM_ADDR !== 8'((c - 1) / 3)) begin failures++; $display("FAIL prog_addr cyc=%0d got=%h exp=%h", c, PM_ADDR, 8'((c - 1) / 3)); end
      end
      if (c == 13) begin
        checks += 2;
        if (DETENIDO !== 1'b1) begin failures++; $display("FAIL prog_det got=%b exp=1", DETENIDO); end
        if (PM_REQ !== 1'b0) begin failures++; $display("FAIL prog_req got=%b exp=0", PM_REQ); end
      end
      @(negedge clk);
    end
    PM_ACK = 1'b0;
  endtask

  task automatic test_sub_jz;
    clear_env();
    init_rf[1] = 8'h02;
    init_rf[2] = 8'h05;
    mem[0] = 16'h3202;
    do_reset();
    step(0);
    checks++;
    if (last_resul !== 8'hFD) begin failures++; $display("FAIL sub_resul got=%h exp=fd", last_resul); end
    clear_env();
    mem[0] = 16'h8040;
    do_reset();
    step(0);
    checks++;
    if (PM_ADDR !== 8'h40) begin failures++; $display("FAIL jz_taken got=%h exp=40", PM_ADDR); end
    init_rf[0] = 8'h01;
    do_reset();
    step(1);
    checks++;
    if (PM_ADDR !== 8'h01) begin failures++; $display("FAIL jz_not_taken got=%h exp=01", PM_ADDR); end
  endtask

  task automatic test_call_ret;
    clear_env();
    mem[0] = 16'h7010;
    mem[8'h10] = 16'h9020;
    mem[8'h20] = 16'hA000;
    do_reset();
    step(0);
    step(0);
    checks += 3;
    if (last_hab !== 3'b011) begin failures++; $display("FAIL call_hab got=%b exp=011", last_hab); end
    if (last_pcval !== 8'h11) begin failures++; $display("FAIL call_pcval got=%h exp=11", last_pcval); end
    if (PM_ADDR !== 8'h20) begin failures++; $display("FAIL call_addr got=%h exp=20", PM_ADDR); end
    step(2);
    checks += 2;
    if (last_rx !== 3'd7) begin failures++; $display("FAIL ret_rx7 got=%h exp=7", last_rx); end
    if (PM_ADDR !== 8'h11) begin failures++; $display("FAIL ret_addr got=%h exp=11", PM_ADDR); end
  endtask

  task automatic test_illegal;
    clear_env();
    mem[0] = 16'hC123;
    do_reset();
    step(0);
    checks += 3;
    if (ERROR !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", ERROR); end
    if (last_hab !== 3'b000) begin failures++; $display("FAIL illegal_hab got=%b exp=000", last_hab); end
    if (PM_ADDR !== 8'h01) begin failures++; $display("FAIL illegal_addr got=%h exp=01", PM_ADDR); end
    step(0);
  endtask

  task automatic test_timeout;
    clear_env();
    do_reset();
    repeat (20) @(negedge clk);
    checks += 3;
    if (ERROR !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", ERROR); end
    if (DETENIDO !== 1'b1) begin failures++; $display("FAIL timeout_det got=%b exp=1", DETENIDO); end
    if (PM_REQ !== 1'b0) begin failures++; $display("FAIL timeout_req got=%b exp=0", PM_REQ); end
    PM_ACK = 1'b1;
    repeat (4) @(negedge clk);
    PM_ACK = 1'b0;
    checks += 2;
    if (DETENIDO !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", DETENIDO); end
    if (HAB !== 3'b000) begin failures++; $display("FAIL halt_hab got=%b exp=000", HAB); end
  endtask

  task automatic test_reset_mid_exec;
    clear_env();
    mem[0] = 16'h1A77;
    do_reset();
    PM_ACK = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (HAB !== 3'b100) begin failures++; $display("FAIL mid_exec_hab got=%b exp=100", HAB); end
    reset = 1'b1;
    #1;
    checks += 2;
    if (HAB !== 3'b000) begin failures++; $display("FAIL mid_rst_hab got=%b exp=000", HAB); end
    if (PM_REQ !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%b exp=0", PM_REQ); end
    PM_ACK = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 3;
    if (PM_ADDR !== 8'h00) begin failures++; $display("FAIL mid_rel_addr got=%h exp=00", PM_ADDR); end
    if (ERROR !== 1'b0) begin failures++; $display("FAIL mid_rel_err got=%b exp=0", ERROR); end
    if (PM_REQ !== 1'b1) begin failures++; $display("FAIL mid_rel_req got=%b exp=1", PM_REQ); end
  endtask

  task automatic test_wrap;
    clear_env();
    mem[0] = 16'h70FF;
    mem[8'hFF] = 16'h90FF;
    do_reset();
    repeat (3) step(0);
    checks += 3;
    if (last_hab !== 3'b011) begin failures++; $display("FAIL wrap_call_hab got=%b exp=011", last_hab); end
    if (last_pcval !== 8'h00) begin failures++; $display("FAIL wrap_pcval got=%h exp=00", last_pcval); end
    if (PM_ADDR !== 8'hFF) begin failures++; $display("FAIL wrap_loop got=%h exp=ff", PM_ADDR); end
    clear_env();
    mem[0] = 16'h70FE;
    do_reset();
    repeat (3) step(1);
    checks++;
    if (PM_ADDR !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h exp=00", PM_ADDR); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      clear_env();
      for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      for (int i = 0; i < 8; i++) init_rf[i] = 8'($urandom);
      do_reset();
      for (int n = 0; n < 150; n++) step($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_sub_jz();
    test_call_ret();
    test_illegal();
    test_timeout();
    test_reset_mid_exec();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
